pcread_req_arbiter: RTL

PCREAD_REQ_ARBITER -- requirements
Module: pcread_req_arbiter

---
 rtl/pcread_req_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pcread_req_arbiter.sv
// Arbitrates pcread requests from NUM_REQ requesters into one registered request stage.
// Id 0 (instruction fetch) has priority, bounded by a starvation limit; ids 1.. share round-robin.
package pcread_req_pkg;
  localparam int TOKEN_W = 4;
  typedef struct packed {
    logic [31:0]        addr;
    logic [3:0]         len;
    logic [TOKEN_W-1:0] token;
  } RequestItem_t;
endpackage

module pcread_req_arbiter
  import pcread_req_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_OUTST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  RequestItem_t               req [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         req_pending,
  input  logic                       drain,
  output logic                       out_valid,
  output RequestItem_t               out_req,
  input  logic                       out_ready,
  input  logic                       ret_valid,
  input  logic                       ret_last,
  input  logic [$clog2(NUM_REQ)-1:0] ret_id,
  output logic                       idle,
  output logic                       err
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]   outst [NUM_REQ];
  logic [SC_W-1:0]    starveCnt;
  logic [ID_W-1:0]    rrPtr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] retHit;
  logic               othersEligible;
  logic               accept;
  logic               rrFound;
  logic [ID_W-1:0]    rrWinner;
  logic [ID_W-1:0]    grantId;
  RequestItem_t       loadReq;

  always_comb begin
    eligible = '0;
    retHit   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (outst[i] < CNT_W'(MAX_OUTST)) && !drain && !reset;
      retHit[i]   = ret_valid && ret_last && (ret_id == ID_W'(i));
    end
  end

  assign othersEligible = |eligible[NUM_REQ-1:1];

  // Round-robin over ids 1..NUM_REQ-1 only, starting just above the last non-zero grant.
  always_comb begin
    int cand;
    cand     = 0;
    rrWinner = '0;
    rrFound  = 1'b0;
    for (int k = 1; k < NUM_REQ; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= NUM_REQ) cand = cand - (NUM_REQ - 1);
      if (!rrFound && eligible[ID_W'(cand)]) begin
        rrWinner = ID_W'(cand);
        rrFound  = 1'b1;
      end
    end
  end

  always_comb begin
    grantId = rrWinner;
    if (eligible[0] && !((starveCnt == SC_W'(STARVE_LIMIT)) && othersEligible)) grantId = '0;
  end

  // Output stage handshake: a request transfers on out_valid && out_ready; the stage
  // may reload in the same cycle it empties, so a grant happens whenever the stage
  // is empty or draining and someone is eligible. Held requests never change.
  assign accept = (!out_valid || out_ready) && (|eligible);

  always_comb begin
    req_grant = '0;
    if (accept) req_grant[grantId] = 1'b1;
  end

  always_comb begin
    loadReq       = req[grantId];
    loadReq.token = TOKEN_W'(grantId);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_req   <= '0;
      starveCnt <= '0;
      rrPtr     <= ID_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_req   <= loadReq;
        if (grantId == '0) begin
          if (!othersEligible)                         starveCnt <= '0;
          else if (starveCnt != SC_W'(STARVE_LIMIT))   starveCnt <= starveCnt + 1'b1;
        end else begin
          starveCnt <= '0;
          rrPtr     <= grantId;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // A return for a requester with nothing outstanding is dropped and flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) outst[i] <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_grant[i] && !(retHit[i] && outst[i] != '0))
          outst[i] <= outst[i] + 1'b1;
        else if (!req_grant[i] && retHit[i] && outst[i] != '0)
          outst[i] <= outst[i] - 1'b1;
        if (retHit[i] && outst[i] == '0) err <= 1'b1;
      end
    end
  end

  always_comb begin
    idle        = !out_valid;
    req_pending = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_pending[i] = (outst[i] != '0) || (out_valid && out_req.token == TOKEN_W'(i));
      if (outst[i] != '0) idle = 1'b0;
    end
  end
endmodule
